// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receiver: FSM states, parity modes,
// oversampling ratio and character length.
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'b00,
        PARITY_EVEN = 2'b01,
        PARITY_ODD  = 2'b10,
        PARITY_RSVD = 2'b11
    } parity_mode_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: one-clk tick every baud_div+1 clocks. The divisor is
// captured at each reload so a changed baud_div never truncates a running period.
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] baud_div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            div_q <= baud_div;
            tick  <= 1'b0;
        end else if (cnt == div_q) begin
            cnt   <= '0;
            div_q <= baud_div;
            tick  <= 1'b1;
        end else begin
            cnt   <= cnt + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_core.sv
// 16x-oversampling UART receiver with an inline show-ahead receive FIFO.
// Define UART_RX_PARITY_EN to build the parity state and parity_err logic.
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rx,
    input  logic                        rx_en,
    input  logic [DIV_W-1:0]            baud_div,
    input  logic [1:0]                  parity_mode,
    input  logic                        rd_en,
    output logic [7:0]                  rd_data,
    output logic                        empty,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] count,
    output logic                        frame_err,
    output logic                        parity_err,
    output logic                        overrun,
    output logic                        tick
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    rx_state_t state, state_n;
    logic [3:0] tcnt, tcnt_n;
    logic [2:0] bit_cnt, bit_n;
    logic [7:0] shreg, sh_n;
    logic bad, bad_n;
    logic push_q, push_n;
    logic ferr_q, ferr_n;
    logic rx_meta, rx_s;
    logic goto_parity;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk      (clk),
        .rst      (rst),
        .baud_div (baud_div),
        .tick     (tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    parity_mode_t pmode;
    logic parity_exp;
    logic perr_q, perr_n;
    assign pmode       = parity_mode_t'(parity_mode);
    assign goto_parity = (pmode == PARITY_EVEN) || (pmode == PARITY_ODD);
    assign parity_exp  = (pmode == PARITY_ODD) ? ~^shreg : ^shreg;
    assign parity_err  = perr_q;
`else
    logic unused_parity;
    assign unused_parity = ^parity_mode;
    assign goto_parity   = 1'b0;
    assign parity_err    = 1'b0;
`endif

    always_comb begin
        state_n = state;
        tcnt_n  = tcnt;
        bit_n   = bit_cnt;
        sh_n    = shreg;
        bad_n   = bad;
        push_n  = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
        perr_n  = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rx_en && !rx_s) begin
                    state_n = START;
                    tcnt_n  = '0;
                    bit_n   = '0;
                    bad_n   = 1'b0;
                end
            end
            // Half a bit into the start bit: still low means a real frame.
            START: begin
                if (tick) begin
                    if (tcnt == 4'(OVERSAMPLE / 2 - 1)) begin
                        tcnt_n  = '0;
                        state_n = rx_s ? IDLE : DATA;
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (tcnt == 4'(OVERSAMPLE - 1)) begin
                        tcnt_n = '0;
                        sh_n   = {rx_s, shreg[7:1]};
                        bit_n  = bit_cnt + 3'd1;
                        if (bit_cnt == 3'(DATA_BITS - 1))
                            state_n = goto_parity ? PARITY : STOP;
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    if (tcnt == 4'(OVERSAMPLE - 1)) begin
                        tcnt_n  = '0;
                        state_n = STOP;
                        if (rx_s != parity_exp) begin
                            perr_n = 1'b1;
                            bad_n  = 1'b1;
                        end
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    if (tcnt == 4'(OVERSAMPLE - 1)) begin
                        tcnt_n  = '0;
                        state_n = IDLE;
                        if (!rx_s)
                            ferr_n = 1'b1;
                        else if (!bad)
                            push_n = 1'b1;
                    end else begin
                        tcnt_n = tcnt + 4'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tcnt    <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            bad     <= 1'b0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            tcnt    <= tcnt_n;
            bit_cnt <= bit_n;
            shreg   <= sh_n;
            bad     <= bad_n;
            push_q  <= push_n;
            ferr_q  <= ferr_n;
`ifdef UART_RX_PARITY_EN
            perr_q  <= perr_n;
`endif
        end
    end

    assign frame_err = ferr_q;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          do_push, do_pop;

    // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
    assign do_pop  = rd_en && !empty;
    assign do_push = push_q && (!full || do_pop);
    assign overrun = push_q && full && !rd_en;
    assign empty   = (count == '0);
    assign full    = (count == CW'(FIFO_DEPTH));
    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= shreg;
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: frame-level decode model plus FIFO queue,
// compared against the DUT every settled cycle. Honours UART_RX_PARITY_EN.
module tb_uart_rx_core;

    localparam int DEPTH    = 16;
    localparam int BIT_CLKS = 64;

    typedef logic bit_q_t[$];

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       rx_en;
    logic [15:0] baud_div;
    logic [1:0] parity_mode;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty, full;
    logic [4:0] count;
    logic       frame_err, parity_err, overrun, tick;

    int tests = 0;
    int fails = 0;
    int ferr_seen = 0, perr_seen = 0, ovr_seen = 0;
    logic fprev = 1'b0, pprev = 1'b0, oprev = 1'b0;
    bit settled = 1'b0;
    logic [7:0] model_q[$];

    uart_rx_core #(.FIFO_DEPTH(DEPTH), .DIV_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .rx_en       (rx_en),
        .baud_div    (baud_div),
        .parity_mode (parity_mode),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .count       (count),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Decode a line waveform (one entry per bit period) the way a UART receiver should.
    function automatic void decodeFrame(input bit_q_t line, input logic [1:0] mode,
                                        output bit push, output bit ferr, output bit perr,
                                        output logic [7:0] data);
        int idx;
        bit par_on;
        logic exp_p;
        logic stop;
        for (int i = 0; i < 8; i++) data[i] = line[1 + i];
        idx = 9;
`ifdef UART_RX_PARITY_EN
        par_on = (mode == 2'b01) || (mode == 2'b10);
`else
        par_on = (mode == 2'b11) && (mode != 2'b11);
`endif
        perr = 1'b0;
        if (par_on) begin
            exp_p = ($countones(data) % 2 == 1) ? (mode == 2'b01) : (mode == 2'b10);
            perr = (line[idx] != exp_p);
            idx++;
        end
        stop = (idx < line.size()) ? line[idx] : 1'b1;
        ferr = !stop;
        push = stop && !perr;
    endfunction

    // Per-cycle compare: pulse widths and pulse tallies always, FIFO view when settled.
    always @(negedge clk) begin
        if (rst) begin
            fprev = 1'b0; pprev = 1'b0; oprev = 1'b0;
        end else begin
            if (frame_err)  begin ferr_seen++; checkOutput("frame_err_width",  32'(fprev), 0); end
            if (parity_err) begin perr_seen++; checkOutput("parity_err_width", 32'(pprev), 0); end
            if (overrun)    begin ovr_seen++;  checkOutput("overrun_width",    32'(oprev), 0); end
            fprev = frame_err; pprev = parity_err; oprev = overrun;
            if (settled) begin
                checkOutput("count",   32'(count),   32'(model_q.size()));
                checkOutput("empty",   32'(empty),   32'(model_q.size() == 0));
                checkOutput("full",    32'(full),    32'(model_q.size() == DEPTH));
                checkOutput("rd_data", 32'(rd_data), (model_q.size() != 0) ? 32'(model_q[0]) : 32'h0);
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input bit has_par, input logic pbit,
                                 input logic stop, input int rst_bit);
        bit_q_t line;
        int f0, p0, o0, len;
        bit e_push, e_ferr, e_perr, e_ovr;
        logic [7:0] e_data;
        f0 = ferr_seen; p0 = perr_seen; o0 = ovr_seen;
        settled = 1'b0;
        line.push_back(1'b0);
        for (int i = 0; i < 8; i++) line.push_back(d[i]);
        if (has_par) line.push_back(pbit);
        line.push_back(stop);
        for (int i = 0; i < line.size(); i++) begin
            rx  = line[i];
            len = (i == line.size() - 1 && !line[i]) ? 44 : BIT_CLKS;
            for (int c = 0; c < len; c++) begin
                @(posedge clk); #1;
                rst = (i == rst_bit && c == 20);
            end
        end
        rx = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        e_ovr = 1'b0;
        if (rst_bit >= 0) begin
            model_q.delete();
            e_ferr = 1'b0; e_perr = 1'b0;
        end else begin
            decodeFrame(line, parity_mode, e_push, e_ferr, e_perr, e_data);
            if (e_push) begin
                if (model_q.size() == DEPTH) e_ovr = 1'b1;
                else model_q.push_back(e_data);
            end
        end
        checkOutput("frame_err_pulses",  32'(ferr_seen - f0), 32'(e_ferr));
        checkOutput("parity_err_pulses", 32'(perr_seen - p0), 32'(e_perr));
        checkOutput("overrun_pulses",    32'(ovr_seen - o0),  32'(e_ovr));
        settled = 1'b1;
    endtask

    task automatic readByte(input logic [7:0] expected);
        checkOutput("read_value", 32'(rd_data), 32'(expected));
        settled = 1'b0;
        rd_en = 1'b1;
        @(posedge clk); #1;
        rd_en = 1'b0;
        if (model_q.size() != 0) void'(model_q.pop_front());
        settled = 1'b1;
    endtask

    initial begin : watchdog
        #10000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int n;
        rx = 1'b1; rx_en = 1'b1; rd_en = 1'b0;
        baud_div = 16'd3; parity_mode = 2'b00; rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("tick_in_reset", 32'(tick), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_count", 32'(count), 0);
        checkOutput("reset_empty", 32'(empty), 1);
        checkOutput("reset_full", 32'(full), 0);
        checkOutput("reset_rd_data", 32'(rd_data), 0);
        checkOutput("reset_errors", {29'd0, frame_err, parity_err, overrun}, 0);
        settled = 1'b1;

        // Tick period with baud_div=3 must be 4 clocks.
        n = 0;
        while (!tick && n < 20) begin @(negedge clk); n++; end
        n = 0;
        do begin @(negedge clk); n++; end while (!tick && n < 20);
        checkOutput("tick_period", 32'(n), 4);
        @(posedge clk); #1;

        applyStimulus(8'hA5, 1'b0, 1'b0, 1'b1, -1);
        checkOutput("a5_rd_data", 32'(rd_data), 32'hA5);
        checkOutput("a5_count", 32'(count), 1);
        readByte(8'hA5);

        parity_mode = 2'b01;
        applyStimulus(8'h03, 1'b1, 1'b1, 1'b1, -1);
`ifdef UART_RX_PARITY_EN
        checkOutput("parity_bad_empty", 32'(empty), 1);
`else
        checkOutput("noparity_rd_data", 32'(rd_data), 32'h03);
        readByte(8'h03);
`endif
        parity_mode = 2'b00;

        applyStimulus(8'h55, 1'b0, 1'b0, 1'b0, -1);
        checkOutput("frame_bad_count", 32'(count), 0);
        repeat (100) @(posedge clk);
        #1;
        applyStimulus(8'h12, 1'b0, 1'b0, 1'b1, -1);
        readByte(8'h12);

        // 2-tick (8 clk) low glitch must be rejected silently.
        n = ferr_seen;
        rx = 1'b0; repeat (8) @(posedge clk);
        #1 rx = 1'b1; repeat (100) @(posedge clk);
        #1;
        checkOutput("glitch_count", 32'(count), 0);
        checkOutput("glitch_no_frame_err", 32'(ferr_seen - n), 0);

        for (int i = 0; i <= DEPTH; i++) applyStimulus(8'(i), 1'b0, 1'b0, 1'b1, -1);
        checkOutput("overflow_full", 32'(full), 1);
        checkOutput("overflow_count", 32'(count), 16);
        for (int i = 0; i < DEPTH; i++) readByte(8'(i));

        applyStimulus(8'h77, 1'b0, 1'b0, 1'b1, -1);
        applyStimulus(8'hFF, 1'b0, 1'b0, 1'b1, 4);
        checkOutput("reset_mid_frame_count", 32'(count), 0);
        applyStimulus(8'h81, 1'b0, 1'b0, 1'b1, -1);
        readByte(8'h81);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, meaning receive FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter DIV_W, default 16, meaning baud divisor width.
REQ-003 SHALL have port clk  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, idle high.
REQ-006 SHALL have port rx_en  input  1  enables start-bit detection.
REQ-007 SHALL have port baud_div  input  DIV_W  tick period minus one, in clk cycles.
REQ-008 SHALL have port parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none.
REQ-009 SHALL have port rd_en  input  1  pop FIFO head.
REQ-010 SHALL have port rd_data  output  8  FIFO head, show-ahead.
REQ-011 SHALL have ports empty, full  output  1 each  FIFO status.
REQ-012 SHALL have port count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-013 SHALL have ports frame_err, parity_err, overrun  output  1 each  single-cycle error pulses.
REQ-014 SHALL have port tick  output  1  16x oversample tick, for debug.

Function
REQ-015 SHALL pass rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-016 SHALL pulse tick for one clk when the divisor counter equals baud_div, then reload the counter to 0; baud_div=0 gives a tick every clk; a new baud_div takes effect at the next reload.
REQ-017 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP; all state-internal counting advances only on tick.
REQ-018 IDLE -> START when rx_en=1 and synchronized rx=0; the tick counter clears on entry.
REQ-019 START SHALL resample rx after 8 ticks: 0 -> DATA, 1 -> IDLE (glitch, no error, no push).
REQ-020 DATA SHALL sample 8 bits, LSB first, every 16 ticks, then go to PARITY if parity is active, else STOP.
REQ-021 PARITY SHALL sample after 16 ticks; a mismatch against even/odd of the 8 data bits pulses parity_err and marks the byte bad.
REQ-022 STOP SHALL sample after 16 ticks: 0 pulses frame_err and marks the byte bad; the FSM then returns to IDLE.
REQ-023 A good byte SHALL be pushed in the clk cycle after the stop sample; bad bytes SHALL NOT be pushed.
REQ-024 A push when full and rd_en=0 SHALL drop the byte and pulse overrun in the push cycle; push with rd_en=1 while full SHALL be accepted.
REQ-025 rd_en when empty SHALL be ignored; simultaneous push and pop when empty SHALL leave count 0->1->... consistent (push wins, pop ignored).
REQ-026 Deasserting rx_en mid-frame SHALL let the frame finish; only new start detection is blocked.
REQ-027 count, empty, full SHALL update in the cycle after a push or pop.

Reset
REQ-028 rst SHALL force IDLE, clear the divisor and bit counters, and empty the FIFO (count=0, empty=1, full=0).
REQ-029 Outputs after reset SHALL be rd_data=0, tick=0, and all error pulses 0; a frame in progress SHALL be abandoned without a push.

Configuration
REQ-030 Macro UART_RX_PARITY_EN defined: the PARITY state and parity_err logic SHALL be present.
REQ-031 Macro UART_RX_PARITY_EN undefined: parity_mode SHALL be ignored, DATA SHALL go directly to STOP, and parity_err SHALL be tied 0.

Structure
REQ-032 The package uart_pkg SHALL hold the FSM state enum, the parity_mode enum, and the constants OVERSAMPLE=16 and DATA_BITS=8.
REQ-033 The tick generator SHALL be the sub-module uart_baud_tick (ports clk, rst, baud_div, tick); the FIFO SHALL remain inline.

Verification
REQ-034 Set baud_div=3 and parity none, then send 0xA5 (64 clk/bit) -> one push; rd_data=0xA5, count=1, no error pulses.
REQ-035 With parity even, send 0x03 with parity bit 1 -> parity_err pulses once, FIFO stays empty (macro defined); undefined build -> byte is framed as data plus stop, and the result is checked per REQ-031.
REQ-036 Send 0x55 with the stop bit driven 0 -> frame_err pulses once, count stays 0, and the next frame 0x12 is received correctly.
REQ-037 Drive a 2-tick low glitch on rx -> returns to IDLE, no push, no error.
REQ-038 Send FIFO_DEPTH+1 bytes 0x00..0x10 with no reads -> full=1, overrun pulses on the last byte, and reads return 0x00..0x0F in order.
REQ-039 Assert rst for one clk in the middle of the DATA bits of 0xFF -> count=0 and no push; the next frame 0x81 is received correctly.
